// File: rtl/adder_bist_driver.sv
// -----------------------------------------------------------------------------
// adder_bist_driver
//
// Built-in self-test engine for a WIDTH-bit adder. It drives {a, b, cin} into
// the adder under test and holds each vector for SETTLE_CYCLES clocks. On the
// last clock of that window it compares the adder's {cout, sum} against an
// internal a+b+cin. A saturating error count and a pass flag summarise the run.
//
// Vector order:
//   vec 0 is all zeros and vec 1 is all ones.
//   vec k >= 2 is the low 2*WIDTH+1 bits of a 32-bit Galois LFSR after (k-1)
//   steps from SEED.
//
// Optional feature (macro ADDER_BIST_FAIL_CAPTURE_EN):
//   When the macro is defined, the first mismatch of a run latches the
//   offending vector and the observed adder outputs onto fail_*_o.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start_i      begin a run (ignored unless idle)
//   abort_i      stop a run in progress (no done pulse)
//   a_o, b_o     registered operands to the adder
//   cin_o        registered carry-in to the adder
//   sum_i        adder sum
//   cout_i       adder carry-out
//   busy_o       run in progress
//   done_o       one-cycle pulse on normal completion
//   pass_o       last completed run had no mismatches
//   err_count_o  saturating mismatch count
//   fail_valid_o, fail_vec_o, fail_sum_o, fail_cout_o
//                first-failure capture (only with ADDER_BIST_FAIL_CAPTURE_EN)
// -----------------------------------------------------------------------------
module adder_bist_driver #(
  parameter int          WIDTH         = 4,
  parameter int          NUM_VECTORS   = 256,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [31:0] SEED          = 32'h1,
  parameter int          ERR_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  output logic               cin_o,
  input  logic [WIDTH-1:0]   sum_i,
  input  logic               cout_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [ERR_W-1:0]   err_count_o
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
  ,
  output logic               fail_valid_o,
  output logic [2*WIDTH:0]   fail_vec_o,
  output logic [WIDTH-1:0]   fail_sum_o,
  output logic               fail_cout_o
`endif
);

  localparam int VEC_W = 2 * WIDTH + 1;
  localparam int IDX_W = (NUM_VECTORS > 2) ? $clog2(NUM_VECTORS) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [31:0]      SEED_EFF   = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;
  localparam logic [31:0]      LFSR_MASK  = 32'h8020_0003;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [VEC_W-1:0] vec_q, vec_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;

  logic [WIDTH:0]   exp_sum;
  logic [WIDTH:0]   obs_sum;
  logic             mismatch;
  logic [31:0]      lfsr_nx;
  logic [ERR_W-1:0] err_inc;
  logic             compare_now;

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
  logic             fv_q, fv_d;
  logic [VEC_W-1:0] fvec_q, fvec_d;
  logic [WIDTH-1:0] fsum_q, fsum_d;
  logic             fcout_q, fcout_d;
`endif

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    if (s[0]) begin
      return (s >> 1) ^ LFSR_MASK;
    end
    return s >> 1;
  endfunction

  assign a_o         = vec_q[VEC_W-1:WIDTH+1];
  assign b_o         = vec_q[WIDTH:1];
  assign cin_o       = vec_q[0];
  assign pass_o      = pass_q;
  assign err_count_o = err_q;

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
  assign fail_valid_o = fv_q;
  assign fail_vec_o   = fvec_q;
  assign fail_sum_o   = fsum_q;
  assign fail_cout_o  = fcout_q;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort has priority over both start and compare.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0 && idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_RUN:   busy_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: vector generation, compare, error accounting.
  always_comb begin
    exp_sum = {1'b0, a_o} + {1'b0, b_o} + {{WIDTH{1'b0}}, cin_o};
    obs_sum = {cout_i, sum_i};
    // if/else so an unknown adder output falls into the mismatch branch
    if (obs_sum == exp_sum) begin
      mismatch = 1'b0;
    end else begin
      mismatch = 1'b1;
    end
    lfsr_nx     = lfsr_step(lfsr_q);
    err_inc     = (mismatch && err_q != ERR_MAX) ? err_q + ERR_W'(1) : err_q;
    compare_now = (state_q == S_RUN) && !abort_i && (cnt_q == '0);

    vec_d  = vec_q;
    lfsr_d = lfsr_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    pass_d = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          vec_d  = '0;
          lfsr_d = SEED_EFF;
          idx_d  = '0;
          cnt_d  = CNT_RELOAD;
          err_d  = '0;
          pass_d = 1'b0;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          pass_d = 1'b0;
        end else if (cnt_q == '0) begin
          err_d = err_inc;
          if (idx_q == LAST_IDX) begin
            pass_d = (err_inc == '0);
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = CNT_RELOAD;
            // vec 1 is the fixed all-ones pattern; the LFSR starts advancing at vec 2
            if (idx_q == '0) begin
              vec_d = '1;
            end else begin
              lfsr_d = lfsr_nx;
              vec_d  = lfsr_nx[VEC_W-1:0];
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
  // First-failure capture: only the first mismatch of a run is kept.
  always_comb begin
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    fsum_d  = fsum_q;
    fcout_d = fcout_q;
    if (state_q == S_IDLE && start_i && !abort_i) begin
      fv_d    = 1'b0;
      fvec_d  = '0;
      fsum_d  = '0;
      fcout_d = 1'b0;
    end else if (compare_now && mismatch && !fv_q) begin
      fv_d    = 1'b1;
      fvec_d  = vec_q;
      fsum_d  = sum_i;
      fcout_d = cout_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fv_q    <= 1'b0;
      fvec_q  <= '0;
      fsum_q  <= '0;
      fcout_q <= 1'b0;
    end else begin
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      fsum_q  <= fsum_d;
      fcout_q <= fcout_d;
    end
  end
`endif

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q  <= '0;
      lfsr_q <= SEED_EFF;
      idx_q  <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      lfsr_q <= lfsr_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      pass_q <= pass_d;
    end
  end

endmodule

// File: tb/tb_adder_bist_driver.sv
`timescale 1ns/1ps
module tb_adder_bist_driver;

  localparam int W  = 4;
  localparam int NV = 8;
  localparam int ST = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         abort_i;
  logic [W-1:0] a_o, b_o, sum_i;
  logic         cin_o, cout_i, busy_o, done_o, pass_o;
  logic [15:0]  err_count_o;
  int           fault;

  logic         s_start;
  logic [W-1:0] s_a, s_b, s_sum;
  logic         s_cin, s_cout, s_busy, s_done, s_pass;
  logic [7:0]   s_err;

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
  logic         fail_valid_o, fail_cout_o;
  logic [8:0]   fail_vec_o;
  logic [W-1:0] fail_sum_o;
  logic         s_fv, s_fcout;
  logic [8:0]   s_fvec;
  logic [W-1:0] s_fsum;
`endif

  always #5 clk = ~clk;

  adder_bist_driver #(.WIDTH(W), .NUM_VECTORS(NV), .SETTLE_CYCLES(ST),
                      .SEED(32'h1), .ERR_W(16)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .a_o(a_o), .b_o(b_o), .cin_o(cin_o), .sum_i(sum_i), .cout_i(cout_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_count_o(err_count_o)
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    , .fail_valid_o(fail_valid_o), .fail_vec_o(fail_vec_o),
    .fail_sum_o(fail_sum_o), .fail_cout_o(fail_cout_o)
`endif
  );

  adder_bist_driver #(.WIDTH(W), .NUM_VECTORS(300), .SETTLE_CYCLES(ST),
                      .SEED(32'h1), .ERR_W(8)) u_sat (
    .clk(clk), .rst(rst), .start_i(s_start), .abort_i(1'b0),
    .a_o(s_a), .b_o(s_b), .cin_o(s_cin), .sum_i(s_sum), .cout_i(s_cout),
    .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass), .err_count_o(s_err)
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    , .fail_valid_o(s_fv), .fail_vec_o(s_fvec),
    .fail_sum_o(s_fsum), .fail_cout_o(s_fcout)
`endif
  );

  // Adder under test: fault 0 = correct, fault 1 = sum[0] stuck at 0.
  function automatic logic [4:0] fake_adder(input logic [8:0] v, input int flt);
    logic [4:0] t;
    t = {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'b0, v[0]};
    if (flt == 1) t[0] = 1'b0;
    return t;
  endfunction

  always_comb begin
    {cout_i, sum_i} = fake_adder({a_o, b_o, cin_o}, fault);
    {s_cout, s_sum} = ~({1'b0, s_a} + {1'b0, s_b} + {4'b0, s_cin});
  end

  function automatic logic [8:0] gen_vec(input int k);
    logic [31:0] s;
    s = 32'h1;
    if (k == 0) return 9'h000;
    if (k == 1) return 9'h1FF;
    for (int i = 0; i < k - 1; i++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s[8:0];
  endfunction

  function automatic logic [4:0] golden(input logic [8:0] v);
    return {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'b0, v[0]};
  endfunction

  function automatic int errs_upto(input int n, input int flt);
    int e;
    e = 0;
    for (int k = 0; k < n; k++) if (fake_adder(gen_vec(k), flt) != golden(gen_vec(k))) e++;
    return e;
  endfunction

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [8:0] exp_vq[$];
  int         exp_eq[$];
  int         bc = 0;
  int         done_cnt = 0;

  // Vector monitor: each new vector (first cycle of its window) is checked.
  always @(negedge clk) begin
    if (rst) bc = 0;
    else begin
      if (done_o) done_cnt++;
      if (busy_o) begin
        if (bc % ST == 0 && exp_vq.size() != 0) check_val("vec", {a_o, b_o, cin_o}, exp_vq.pop_front());
        bc++;
      end else bc = 0;
    end
  end

  task automatic push_run(input int flt);
    for (int k = 0; k < NV; k++) exp_vq.push_back(gen_vec(k));
    exp_eq.push_back(errs_upto(NV, flt));
  endtask

  task automatic pulse_start();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
  endtask

  task automatic run_full(input int flt, input bit extra_start);
    int cyc, d0, errs;
    fault = flt;
    push_run(flt);
    errs = errs_upto(NV, flt);
    d0 = done_cnt;
    pulse_start();
    cyc = 1;
    check_val("busy_on", busy_o, 1);
    check_val("err_clr", err_count_o, 0);
    while (!done_o && cyc < 200) begin
      @(negedge clk); cyc++;
      start_i = extra_start && (cyc == 5);
    end
    start_i = 1'b0;
    check_val("done_lat", cyc, NV * ST + 1);
    check_val("busy_off", busy_o, 0);
    check_val("pass", pass_o, (errs == 0));
    check_val("err_count", err_count_o, exp_eq.pop_front());
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    check_val("fail_valid", fail_valid_o, (errs != 0));
    if (errs != 0) begin
      check_val("fail_vec", fail_vec_o, 9'h1FF);
      check_val("fail_sum", fail_sum_o, 4'hE);
      check_val("fail_cout", fail_cout_o, 1);
    end
`endif
    @(negedge clk);
    check_val("done_pulses", done_cnt - d0, 1);
    check_val("hold_vec", {a_o, b_o, cin_o}, gen_vec(NV - 1));
    check_val("vq_empty", exp_vq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, d0, held;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; s_start = 1'b0; fault = 0;
    repeat (3) @(negedge clk);
    check_val("rst_vec", {a_o, b_o, cin_o}, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_pass", pass_o, 0);
    check_val("rst_err", err_count_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // Golden adder, then stuck-at fault, then ignored second start.
    run_full(0, 1'b0);
    run_full(1, 1'b0);
    run_full(0, 1'b1);

    // Abort at cycle 7 of a faulty run.
    fault = 1;
    push_run(1);
    void'(exp_eq.pop_back());
    d0 = done_cnt;
    pulse_start();
    cyc = 1;
    while (cyc < 7) begin @(negedge clk); cyc++; end
    abort_i = 1'b1;
    @(negedge clk); abort_i = 1'b0;
    check_val("abort_busy", busy_o, 0);
    check_val("abort_pass", pass_o, 0);
    check_val("abort_err", err_count_o, errs_upto(3, 1));
    exp_vq.delete();
    repeat (20) @(negedge clk);
    check_val("abort_nodone", done_cnt - d0, 0);
    held = err_count_o;

    // abort and start together while idle: no run starts.
    @(negedge clk); start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk); start_i = 1'b0; abort_i = 1'b0;
    check_val("abort_wins_busy", busy_o, 0);
    check_val("abort_wins_err", err_count_o, held);
    run_full(0, 1'b0);

    // Reset in the middle of a faulty run.
    fault = 1;
    push_run(1);
    void'(exp_eq.pop_back());
    d0 = done_cnt;
    pulse_start();
    cyc = 1;
    while (cyc < 9) begin @(negedge clk); cyc++; end
    check_val("pre_rst_err", err_count_o, errs_upto(4, 1));
    rst = 1'b1;
    #1;
    check_val("mid_rst_vec", {a_o, b_o, cin_o}, 0);
    check_val("mid_rst_busy", busy_o, 0);
    check_val("mid_rst_err", err_count_o, 0);
    @(negedge clk);
    check_val("mid_rst_err2", err_count_o, 0);
    @(negedge clk); rst = 1'b0;
    exp_vq.delete();
    check_val("rst_nodone", done_cnt - d0, 0);
    run_full(0, 1'b0);

    // Saturating error counter on the 300-vector instance.
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    cyc = 1;
    while (!s_done && cyc < 1000) begin @(negedge clk); cyc++; end
    check_val("sat_lat", cyc, 300 * ST + 1);
    check_val("sat_err", s_err, 8'hFF);
    check_val("sat_pass", s_pass, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
